des_decrypt_iter: RTL and testbench

//  Iterative DES decryption engine; inverse direction of the DES encryption datapath.

---
 rtl/des_decrypt_iter.sv | 236 +++++++++++++++++++++++
 tb/tb_des_decrypt_iter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption engine. Runs 16 Feistel rounds with UNROLL rounds per clock.
// The reverse key schedule is derived on the fly by right-rotating the PC-1 halves.
module des_decrypt_iter #(
  parameter int UNROLL     = 1,
  parameter bit PARITY_CHK = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [63:0] CIPHER_TEXT,
  input  logic [63:0] KEY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] PLAIN_TEXT,
  output logic        KEY_ERR
);

  localparam logic [3:0] CNT_LAST = 4'(16 / UNROLL - 1);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Eight boxes, each 4 rows x 16 columns, indexed {box, row, col}.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  // Table entries are 1-based with DES bit 1 at the MSB.
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], 1'(x >> (64 - IP_T[i]))};
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], 1'(x >> (64 - FP_T[i]))};
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] y = '0;
    for (int i = 0; i < 56; i++) y = {y[54:0], 1'(k >> (64 - PC1_T[i]))};
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], 1'(cd >> (56 - PC2_T[i]))};
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] ex = '0;
    logic [31:0] sb = '0;
    logic [31:0] y  = '0;
    logic [5:0]  b;
    logic [8:0]  si;
    for (int i = 0; i < 48; i++) ex = {ex[46:0], 1'(r >> (32 - E_T[i]))};
    ex = ex ^ k;
    for (int s = 0; s < 8; s++) begin
      b  = 6'(ex >> (42 - 6 * s));
      si = {3'(s), b[5], b[0], b[4:1]};
      sb = {sb[27:0], SBOX[si][3:0]};
    end
    for (int i = 0; i < 32; i++) y = {y[30:0], 1'(sb >> (32 - P_T[i]))};
    return y;
  endfunction

  // Undo the encryption left shifts: none before round 1, one before rounds 2/9/16, else two.
  function automatic logic [55:0] key_rot(input logic [55:0] cd, input logic [4:0] rnd);
    logic [27:0] c = cd[55:28];
    logic [27:0] d = cd[27:0];
    if (rnd == 5'd0) return cd;
    if (rnd == 5'd1 || rnd == 5'd8 || rnd == 5'd15)
      return {c[0], c[27:1], d[0], d[27:1]};
    return {c[1:0], c[27:2], d[1:0], d[27:2]};
  endfunction

  function automatic logic key_parity_err(input logic [63:0] k);
    logic err = 1'b0;
    for (int b = 0; b < 8; b++) err = err | ~(^8'(k >> (8 * b)));
    return err;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_OUT} state_t;

  state_t      state_q, state_n;
  logic [3:0]  cnt_p0;
  logic [31:0] l_p0, r_p0;
  logic [55:0] cd_p0;
  logic [31:0] l_n, r_n, fx;
  logic [55:0] cd_n;
  logic [47:0] rk;
  logic [4:0]  rnd;
  logic [63:0] pt_p1;
  logic        vld_p1;
  logic        key_err_q;
  logic        accept, last_round, parity_err;

  assign accept     = (state_q == S_IDLE) && IN_VALID;
  assign last_round = (state_q == S_ROUND) && (cnt_p0 == CNT_LAST);
  assign parity_err = PARITY_CHK ? key_parity_err(KEY) : 1'b0;

  assign IN_READY   = (state_q == S_IDLE);
  assign OUT_VALID  = vld_p1;
  assign PLAIN_TEXT = pt_p1;
  assign KEY_ERR    = key_err_q;

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (IN_VALID) state_n = S_ROUND;
      S_ROUND: if (cnt_p0 == CNT_LAST) state_n = S_OUT;
      S_OUT:   if (OUT_READY) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    l_n  = l_p0;
    r_n  = r_p0;
    cd_n = cd_p0;
    rk   = '0;
    fx   = '0;
    rnd  = '0;
    for (int u = 0; u < UNROLL; u++) begin
      rnd  = 5'(int'(cnt_p0) * UNROLL + u);
      cd_n = key_rot(cd_n, rnd);
      rk   = pc2(cd_n);
      fx   = l_n ^ feistel(r_n, rk);
      l_n  = r_n;
      r_n  = fx;
    end
  end

  // Stage p0: round state, loaded at accept and iterated in ROUND.
  always_ff @(posedge CLK) begin
    if (accept) begin
      {l_p0, r_p0} <= ip(CIPHER_TEXT);
      cd_p0        <= pc1(KEY);
    end else if (state_q == S_ROUND) begin
      l_p0  <= l_n;
      r_p0  <= r_n;
      cd_p0 <= cd_n;
    end
  end

  // Stage p1: registered plaintext and its valid flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_p0    <= '0;
      pt_p1     <= '0;
      vld_p1    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        cnt_p0    <= '0;
        key_err_q <= parity_err;
      end else if (state_q == S_ROUND) begin
        cnt_p0 <= cnt_p0 + 4'd1;
      end
      if (last_round) begin
        pt_p1  <= fp({r_n, l_n});
        vld_p1 <= 1'b1;
      end else if (vld_p1 && OUT_READY) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter using known DES vectors, backpressure,
// mid-operation reset and back-to-back blocks.
module tb_des_decrypt_iter;

  localparam int UNROLL = 1;
  localparam int LAT    = 16 / UNROLL;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [63:0] CIPHER_TEXT;
  logic [63:0] KEY;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] PLAIN_TEXT;
  logic        KEY_ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  des_decrypt_iter #(.UNROLL(UNROLL), .PARITY_CHK(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .CIPHER_TEXT(CIPHER_TEXT), .KEY(KEY), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .PLAIN_TEXT(PLAIN_TEXT), .KEY_ERR(KEY_ERR)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input string tag, input logic [63:0] ct, input logic [63:0] key);
    int n = 0;
    while (!IN_READY && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
    CIPHER_TEXT = ct;
    KEY         = key;
    IN_VALID    = 1'b1;
    tick();
    IN_VALID    = 1'b0;
    CIPHER_TEXT = ~ct;
    KEY         = ~key;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] pt, input logic err);
    int n = 0;
    while (!OUT_VALID && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    chk({tag, "_pt"}, PLAIN_TEXT, pt);
    chk({tag, "_key_err"}, 64'(KEY_ERR), 64'(err));
    chk({tag, "_busy"}, 64'(IN_READY), 64'd0);
  endtask

  task automatic release_out(input string tag);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, "_ovld_clr"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_idle"}, 64'(IN_READY), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    RST_N       = 1'b0;
    IN_VALID    = 1'b0;
    OUT_READY   = 1'b0;
    CIPHER_TEXT = '0;
    KEY         = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_pt", PLAIN_TEXT, 64'd0);
    chk("rst_key_err", 64'(KEY_ERR), 64'd0);
    RST_N = 1'b1;
    tick();
    tick();
    chk("idle_hold", 64'(IN_READY), 64'd1);

    send("t1", 64'h85E813540F0AB405, 64'h133457799BBCDFF1);
    expect_out("t1", 64'h0123456789ABCDEF, 1'b0);
    release_out("t1");

    send("t2", 64'h0000000000000000, 64'h0E329232EA6D0D73);
    expect_out("t2", 64'h8787878787878787, 1'b0);
    for (int i = 0; i < 10; i++) begin
      IN_VALID    = (i % 2 == 0);
      CIPHER_TEXT = {$urandom, $urandom};
      KEY         = {$urandom, $urandom};
      tick();
      chk("bp_pt", PLAIN_TEXT, 64'h8787878787878787);
      chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
      chk("bp_in_ready", 64'(IN_READY), 64'd0);
    end
    IN_VALID = 1'b0;
    release_out("bp");

    send("zero_key", 64'h8CA64DE9C1B123A7, 64'h0000000000000000);
    expect_out("zero_key", 64'h0000000000000000, 1'b1);
    release_out("zero_key");

    send("t3", 64'h85E813540F0AB405, 64'h133457799BBCDFF0);
    expect_out("t3", 64'h0123456789ABCDEF, 1'b1);
    release_out("t3");

    send("mid", 64'h85E813540F0AB405, 64'h133457799BBCDFF1);
    repeat (6) tick();
    RST_N = 1'b0;
    tick();
    chk("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_pt", PLAIN_TEXT, 64'd0);
    chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
    chk("mid_rst_key_err", 64'(KEY_ERR), 64'd0);
    RST_N = 1'b1;
    repeat (20) tick();
    chk("mid_abort", 64'(OUT_VALID), 64'd0);
    send("post_rst", 64'h0000000000000000, 64'h0E329232EA6D0D73);
    expect_out("post_rst", 64'h8787878787878787, 1'b0);
    release_out("post_rst");

    send("b2b_a", 64'h85E813540F0AB405, 64'h133457799BBCDFF1);
    expect_out("b2b_a", 64'h0123456789ABCDEF, 1'b0);
    release_out("b2b_a");
    send("b2b_b", 64'h8CA64DE9C1B123A7, 64'h0000000000000000);
    expect_out("b2b_b", 64'h0000000000000000, 1'b1);
    release_out("b2b_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
